// File: rtl/uc_prog_mem_server.sv
`default_nettype none
// ==========================================================================================
// uc_prog_mem_server - host-loaded program memory with a registered fetch port; rev 1.0
// Define UC_PM_PARITY_EN to store and check an even-parity bit per stored word.
// ==========================================================================================
module uc_prog_mem_server #(
   parameter int DEPTH_W = 8,
   parameter int DATA_W  = 16
) (
   input  logic               clk,
   input  logic               arst_n,
   input  logic               load_start,
   input  logic [DEPTH_W:0]   load_len,
   input  logic               wr_valid,
   input  logic [DATA_W-1:0]  wr_data,
   output logic               wr_ready,
   input  logic [11:0]        pc_addr,
   output logic [DATA_W-1:0]  flash_data,
   output logic               clk_valid,
   output logic               booting,
   output logic [DEPTH_W:0]   load_cnt,
   output logic               err
);

   localparam int               c_WORDS   = 1 << DEPTH_W;
   localparam logic [DEPTH_W:0] c_MAX_LEN = {1'b1, {DEPTH_W{1'b0}}};
   localparam logic [DEPTH_W:0] c_ONE     = {{DEPTH_W{1'b0}}, 1'b1};
`ifdef UC_PM_PARITY_EN
   localparam int               c_MEM_W   = DATA_W + 1;
`else
   localparam int               c_MEM_W   = DATA_W;
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   state_t             r_state;
   logic [DEPTH_W:0]   r_len;
   logic [c_MEM_W-1:0] r_mem [c_WORDS];

   logic               w_fire;
   logic               w_len_ovf;
   logic [DEPTH_W:0]   w_len_sat;
   logic [DEPTH_W:0]   w_cnt_nxt;
   logic               w_addr_oob;
   logic [c_MEM_W-1:0] w_rd_word;
   logic [c_MEM_W-1:0] w_wr_word;
   logic               w_rd_bad;

   // A load_start in the same cycle aborts the load, so that word is not committed.
   assign w_fire     = wr_ready & wr_valid & ~load_start;
   assign w_len_ovf  = (load_len > c_MAX_LEN);
   assign w_len_sat  = w_len_ovf ? c_MAX_LEN : load_len;
   assign w_cnt_nxt  = load_cnt + c_ONE;
   assign w_addr_oob = ((pc_addr >> DEPTH_W) != 12'd0);
   assign w_rd_word  = r_mem[pc_addr[DEPTH_W-1:0]];

`ifdef UC_PM_PARITY_EN
   assign w_wr_word  = {^wr_data, wr_data};
   assign w_rd_bad   = ^w_rd_word;
`else
   assign w_wr_word  = wr_data;
   assign w_rd_bad   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (w_fire) begin
         r_mem[load_cnt[DEPTH_W-1:0]] <= w_wr_word;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state    <= ST_IDLE;
         r_len      <= '0;
         load_cnt   <= '0;
         wr_ready   <= 1'b0;
         clk_valid  <= 1'b0;
         booting    <= 1'b0;
         flash_data <= '0;
         err        <= 1'b0;
      end else begin
         if (load_start) begin
            load_cnt <= '0;
            r_len    <= w_len_sat;
            err      <= w_len_ovf;
            if (w_len_sat == '0) begin
               r_state   <= ST_RUN;
               wr_ready  <= 1'b0;
               clk_valid <= 1'b1;
               booting   <= 1'b0;
            end else begin
               r_state   <= ST_LOAD;
               wr_ready  <= 1'b1;
               clk_valid <= 1'b0;
               booting   <= 1'b1;
            end
         end else if (r_state == ST_LOAD && w_fire) begin
            load_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == r_len) begin
               r_state   <= ST_RUN;
               wr_ready  <= 1'b0;
               clk_valid <= 1'b1;
               booting   <= 1'b0;
            end
         end

         // Leaving RUN always goes through load_start, so clearing here keeps the output 0 outside RUN.
         if (r_state == ST_RUN && !load_start) begin
            if (w_addr_oob || w_rd_bad) begin
               flash_data <= '0;
               err        <= 1'b1;
            end else begin
               flash_data <= w_rd_word[DATA_W-1:0];
            end
         end else begin
            flash_data <= '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uc_prog_mem_server.sv
`default_nettype none
// Directed self-checking bench for uc_prog_mem_server (DEPTH_W=8, DATA_W=16).
module tb_uc_prog_mem_server;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        load_start;
   logic [8:0]  load_len;
   logic        wr_valid;
   logic [15:0] wr_data;
   logic        wr_ready;
   logic [11:0] pc_addr;
   logic [15:0] flash_data;
   logic        clk_valid;
   logic        booting;
   logic [8:0]  load_cnt;
   logic        err;

   int n_tests = 0;
   int n_fail  = 0;

   uc_prog_mem_server #(.DEPTH_W(8), .DATA_W(16)) dut (
      .clk        (clk),
      .arst_n     (arst_n),
      .load_start (load_start),
      .load_len   (load_len),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .pc_addr    (pc_addr),
      .flash_data (flash_data),
      .clk_valid  (clk_valid),
      .booting    (booting),
      .load_cnt   (load_cnt),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input logic [8:0] len);
      load_start = 1'b1;
      load_len   = len;
      tick();
      load_start = 1'b0;
   endtask

   task automatic read_chk(input string tag, input logic [11:0] a, input logic [15:0] exp);
      pc_addr = a;
      tick();
      check(tag, 32'(flash_data), 32'(exp));
   endtask

   task automatic chk_reset_outs(input string tag);
      check({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
      check({tag, "_clk_valid"}, 32'(clk_valid), 32'd0);
      check({tag, "_booting"}, 32'(booting), 32'd0);
      check({tag, "_load_cnt"}, 32'(load_cnt), 32'd0);
      check({tag, "_flash"}, 32'(flash_data), 32'd0);
      check({tag, "_err"}, 32'(err), 32'd0);
   endtask

   initial begin
      arst_n     = 1'b1;
      load_start = 1'b0;
      load_len   = '0;
      wr_valid   = 1'b0;
      wr_data    = '0;
      pc_addr    = '0;
      #2 arst_n  = 1'b0;
      tick();
      tick();
      chk_reset_outs("rst");
      arst_n = 1'b1;
      tick();

      // Three-word load with wr_valid held high
      start_load(9'd3);
      wr_valid = 1'b1;
      wr_data  = 16'hA5A5;
      check("l3_booting", 32'(booting), 32'd1);
      check("l3_flash_load", 32'(flash_data), 32'd0);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("l3_wr_ready%0d", i), 32'(wr_ready), 32'd1);
         check($sformatf("l3_clk_valid%0d", i), 32'(clk_valid), 32'd0);
         tick();
         wr_data = (i == 0) ? 16'h1234 : 16'hFFFF;
      end
      wr_valid = 1'b0;
      check("l3_clk_valid", 32'(clk_valid), 32'd1);
      check("l3_wr_ready_off", 32'(wr_ready), 32'd0);
      check("l3_booting_off", 32'(booting), 32'd0);
      check("l3_cnt", 32'(load_cnt), 32'd3);
      read_chk("l3_rd1", 12'd1, 16'h1234);
      read_chk("l3_rd0", 12'd0, 16'hA5A5);
      read_chk("l3_rd2", 12'd2, 16'hFFFF);
      check("l3_err", 32'(err), 32'd0);

      // wr_valid in RUN must be ignored
      wr_valid = 1'b1;
      wr_data  = 16'hDEAD;
      tick();
      wr_valid = 1'b0;
      check("run_ign_cnt", 32'(load_cnt), 32'd3);
      read_chk("run_ign_rd0", 12'd0, 16'hA5A5);

      // Out-of-range fetch, then sticky err
      read_chk("oob_flash", 12'h100, 16'h0000);
      check("oob_err", 32'(err), 32'd1);
      read_chk("oob_sticky_rd", 12'd1, 16'h1234);
      check("oob_sticky_err", 32'(err), 32'd1);

      // Toggling wr_valid: only handshaked words count
      start_load(9'd4);
      check("tg_err_clr", 32'(err), 32'd0);
      check("tg_booting", 32'(booting), 32'd1);
      wr_valid = 1'b1; wr_data = 16'h1111; tick();
      check("tg_cnt1", 32'(load_cnt), 32'd1);
      wr_valid = 1'b0; wr_data = 16'hBAD0; tick();
      check("tg_cnt1_hold", 32'(load_cnt), 32'd1);
      wr_valid = 1'b1; wr_data = 16'h2222; tick();
      check("tg_cnt2", 32'(load_cnt), 32'd2);
      wr_valid = 1'b0; wr_data = 16'hBAD1; tick();
      check("tg_cnt2_hold", 32'(load_cnt), 32'd2);
      wr_valid = 1'b1; wr_data = 16'h3333; tick();
      wr_data = 16'h4444; tick();
      wr_valid = 1'b0;
      check("tg_cnt4", 32'(load_cnt), 32'd4);
      check("tg_run", 32'(clk_valid), 32'd1);
      read_chk("tg_rd0", 12'd0, 16'h1111);
      read_chk("tg_rd1", 12'd1, 16'h2222);
      read_chk("tg_rd2", 12'd2, 16'h3333);
      read_chk("tg_rd3", 12'd3, 16'h4444);

      // Zero-length load goes straight to RUN
      wr_valid = 1'b1;
      wr_data  = 16'hBEEF;
      start_load(9'd0);
      check("z_clk_valid", 32'(clk_valid), 32'd1);
      check("z_booting", 32'(booting), 32'd0);
      check("z_cnt", 32'(load_cnt), 32'd0);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("z_wr_ready%0d", i), 32'(wr_ready), 32'd0);
         tick();
      end
      wr_valid = 1'b0;
      read_chk("z_rd0", 12'd0, 16'h1111);

      // Restart after 2 of 4 words; memory retained
      start_load(9'd4);
      wr_valid = 1'b1;
      wr_data = 16'h5555; tick();
      wr_data = 16'h6666; tick();
      check("ab_cnt2", 32'(load_cnt), 32'd2);
      wr_valid = 1'b0;
      start_load(9'd1);
      check("ab_cnt0", 32'(load_cnt), 32'd0);
      check("ab_booting", 32'(booting), 32'd1);
      check("ab_clk_valid", 32'(clk_valid), 32'd0);
      wr_valid = 1'b1; wr_data = 16'h8888; tick();
      wr_valid = 1'b0;
      check("ab_run", 32'(clk_valid), 32'd1);
      check("ab_cnt1", 32'(load_cnt), 32'd1);
      read_chk("ab_rd0", 12'd0, 16'h8888);
      read_chk("ab_rd1", 12'd1, 16'h6666);
      read_chk("ab_rd2", 12'd2, 16'h3333);

      // Oversized length saturates to 256 words and sets err
      start_load(9'h1FF);
      check("sat_err", 32'(err), 32'd1);
      wr_valid = 1'b1;
      for (int i = 0; i < 256; i++) begin
         wr_data = 16'(i) ^ 16'hC3C3;
         if (i == 255) check("sat_not_run", 32'(clk_valid), 32'd0);
         tick();
      end
      wr_valid = 1'b0;
      check("sat_run", 32'(clk_valid), 32'd1);
      check("sat_cnt", 32'(load_cnt), 32'h100);
      check("sat_err_sticky", 32'(err), 32'd1);
      read_chk("sat_rd255", 12'd255, 16'hC33C);

      // Exactly 256 is legal; async reset mid-load
      start_load(9'h100);
      check("full_err", 32'(err), 32'd0);
      wr_valid = 1'b1; wr_data = 16'h9999; tick();
      check("rl_cnt1", 32'(load_cnt), 32'd1);
      #2 arst_n = 1'b0;
      #1;
      chk_reset_outs("arst");
      arst_n = 1'b1;
      tick();
      tick();
      check("post_rst_wr_ready", 32'(wr_ready), 32'd0);
      check("post_rst_booting", 32'(booting), 32'd0);
      check("post_rst_cnt", 32'(load_cnt), 32'd0);
      wr_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
